// File: rtl/dijkstra_wram_sched.sv
// Purpose: round-robin scheduler for the single-port weights RAM shared by the core (row fetch) and the host loader.
// Latency: grants are combinational in IDLE; row word w is presented RAM_LATENCY cycles after its read is issued.
// Backpressure: requesters hold their request until granted; a granted row fetch always runs to completion.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   row_req_i/row_vidx_i/row_vnum_i   core row-fetch request (held until row_gnt_o)
//   row_gnt_o, err_o            row accepted / illegal row request dropped (1-cycle pulses)
//   row_data_o/row_mask_o/row_valid_o/row_last_o   streamed row words
//   host_wr_req_i/host_wr_addr_i/host_wr_data_i, host_wr_gnt_o   host single-word writes
//   ram_cs_o/ram_we_o/ram_addr_o/ram_wdata_o/ram_rdata_i         RAM port
//   busy_o                      FSM not in IDLE
module dijkstra_wram_sched #(
  parameter int VIRTEX_DWIDTH    = 16,
  parameter int VIRTEX_NUM_WIDTH = 6,
  parameter int PIPE_WIDTH       = 4,
  parameter int RAM_LATENCY      = 1,
  localparam int PIPE_SHIFT      = $clog2(PIPE_WIDTH),
  localparam int AW              = 2*VIRTEX_NUM_WIDTH - PIPE_SHIFT,
  localparam int WW              = PIPE_WIDTH*VIRTEX_DWIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        row_req_i,
  input  logic [VIRTEX_NUM_WIDTH-1:0] row_vidx_i,
  input  logic [VIRTEX_NUM_WIDTH:0]   row_vnum_i,
  output logic                        row_gnt_o,
  output logic [WW-1:0]               row_data_o,
  output logic [PIPE_WIDTH-1:0]       row_mask_o,
  output logic                        row_valid_o,
  output logic                        row_last_o,
  input  logic                        host_wr_req_i,
  input  logic [AW-1:0]               host_wr_addr_i,
  input  logic [WW-1:0]               host_wr_data_i,
  output logic                        host_wr_gnt_o,
  output logic                        ram_cs_o,
  output logic                        ram_we_o,
  output logic [AW-1:0]               ram_addr_o,
  output logic [WW-1:0]               ram_wdata_o,
  input  logic [WW-1:0]               ram_rdata_i,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int NW        = VIRTEX_NUM_WIDTH + 1;
  localparam int ROW_WORDS = (2**VIRTEX_NUM_WIDTH) / PIPE_WIDTH;
  localparam logic [NW-1:0] VNUM_MAX = NW'(2**VIRTEX_NUM_WIDTH);

  // last_gnt encoding
  localparam logic GNT_HOST = 1'b0;
  localparam logic GNT_ROW  = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, ROW_RD = 2'd1, DRAIN = 2'd2} state_e;

  // One read-pipe stage: tags travelling alongside the RAM read latency
  typedef struct packed {
    logic                  vld;
    logic                  last;
    logic [PIPE_WIDTH-1:0] mask;
  } rdpipe_t;

  state_e                      state_q, state_d;
  logic                        last_gnt_q, last_gnt_d;
  logic [VIRTEX_NUM_WIDTH-1:0] vidx_q, vidx_d;
  logic [NW-1:0]               vnum_q, vnum_d;
  logic [NW-1:0]               nwords_q, nwords_d;
  logic [NW-1:0]               wcnt_q, wcnt_d;
  rdpipe_t                     pipe_q [RAM_LATENCY];
  rdpipe_t                     pipe_in;
  rdpipe_t                     pipe_out;

  logic                        row_win;
  logic                        host_win;
  logic                        row_illegal;
  logic [NW:0]                 nw_sum;
  logic [NW-1:0]               nwords_req;
  logic                        last_word;
  logic [AW-1:0]               row_addr;
  logic [PIPE_WIDTH-1:0]       word_mask;

  // Round-robin: with both pending, the side opposite last_gnt wins.
  assign row_win  = row_req_i & (~host_wr_req_i | (last_gnt_q == GNT_HOST));
  assign host_win = host_wr_req_i & (~row_req_i | (last_gnt_q == GNT_ROW));

  assign row_illegal = (row_vnum_i == '0) || (row_vnum_i > VNUM_MAX) ||
                       ({1'b0, row_vidx_i} >= row_vnum_i);

  // Words per row, rounded up; one spare bit keeps the add from wrapping.
  assign nw_sum     = {1'b0, row_vnum_i} + (NW+1)'(PIPE_WIDTH-1);
  assign nwords_req = NW'(nw_sum >> PIPE_SHIFT);

  assign last_word = (wcnt_q == nwords_q - NW'(1));
  assign row_addr  = AW'(vidx_q) * AW'(ROW_WORDS) + AW'(wcnt_q);

  always_comb begin
    word_mask = '0;
    for (int i = 0; i < PIPE_WIDTH; i++) begin
      word_mask[i] = (int'(wcnt_q) * PIPE_WIDTH + i) < int'(vnum_q);
    end
  end

  assign pipe_out = pipe_q[RAM_LATENCY-1];

  assign row_valid_o = pipe_out.vld;
  assign row_last_o  = pipe_out.vld & pipe_out.last;
  assign row_mask_o  = pipe_out.mask;
  assign row_data_o  = pipe_out.vld ? ram_rdata_i : '0;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    last_gnt_d    = last_gnt_q;
    vidx_d        = vidx_q;
    vnum_d        = vnum_q;
    nwords_d      = nwords_q;
    wcnt_d        = wcnt_q;
    row_gnt_o     = 1'b0;
    host_wr_gnt_o = 1'b0;
    err_o         = 1'b0;
    ram_cs_o      = 1'b0;
    ram_we_o      = 1'b0;
    ram_addr_o    = '0;
    ram_wdata_o   = '0;
    pipe_in       = '0;

    case (state_q)
      IDLE: begin
        if (row_win) begin
          if (row_illegal) begin
            // Dropped request: no access, arbitration history untouched.
            err_o = 1'b1;
          end else begin
            row_gnt_o  = 1'b1;
            vidx_d     = row_vidx_i;
            vnum_d     = row_vnum_i;
            nwords_d   = nwords_req;
            wcnt_d     = '0;
            last_gnt_d = GNT_ROW;
            state_d    = ROW_RD;
          end
        end else if (host_win) begin
          host_wr_gnt_o = 1'b1;
          ram_cs_o      = 1'b1;
          ram_we_o      = 1'b1;
          ram_addr_o    = host_wr_addr_i;
          ram_wdata_o   = host_wr_data_i;
          last_gnt_d    = GNT_HOST;
        end
      end

      ROW_RD: begin
        ram_cs_o     = 1'b1;
        ram_addr_o   = row_addr;
        pipe_in.vld  = 1'b1;
        pipe_in.last = last_word;
        pipe_in.mask = word_mask;
        if (last_word) begin
          wcnt_d  = '0;
          state_d = DRAIN;
        end else begin
          wcnt_d = wcnt_q + NW'(1);
        end
      end

      DRAIN: begin
        if (pipe_out.vld && pipe_out.last) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= GNT_ROW;
      vidx_q     <= '0;
      vnum_q     <= '0;
      nwords_q   <= '0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      vidx_q     <= vidx_d;
      vnum_q     <= vnum_d;
      nwords_q   <= nwords_d;
      wcnt_q     <= wcnt_d;
    end
  end

  // Tag pipe matched to the RAM read latency; cleared on reset so an
  // aborted fetch never presents stale words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RAM_LATENCY; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      pipe_q[0] <= pipe_in;
      for (int s = 1; s < RAM_LATENCY; s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

endmodule

// File: tb/tb_dijkstra_wram_sched.sv
// Purpose: directed self-checking bench for dijkstra_wram_sched with a behavioural 1-cycle RAM.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: requests are held until granted, as the core and host would.
module tb_dijkstra_wram_sched;

  localparam int DW  = 16;
  localparam int VNW = 6;
  localparam int PW  = 4;
  localparam int RL  = 1;
  localparam int AW  = 10;
  localparam int WW  = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           row_req_i;
  logic [VNW-1:0] row_vidx_i;
  logic [VNW:0]   row_vnum_i;
  logic           row_gnt_o;
  logic [WW-1:0]  row_data_o;
  logic [PW-1:0]  row_mask_o;
  logic           row_valid_o;
  logic           row_last_o;
  logic           host_wr_req_i;
  logic [AW-1:0]  host_wr_addr_i;
  logic [WW-1:0]  host_wr_data_i;
  logic           host_wr_gnt_o;
  logic           ram_cs_o;
  logic           ram_we_o;
  logic [AW-1:0]  ram_addr_o;
  logic [WW-1:0]  ram_wdata_o;
  logic [WW-1:0]  ram_rdata_i;
  logic           busy_o;
  logic           err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dijkstra_wram_sched #(
    .VIRTEX_DWIDTH(DW), .VIRTEX_NUM_WIDTH(VNW), .PIPE_WIDTH(PW), .RAM_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .row_req_i(row_req_i), .row_vidx_i(row_vidx_i), .row_vnum_i(row_vnum_i),
    .row_gnt_o(row_gnt_o), .row_data_o(row_data_o), .row_mask_o(row_mask_o),
    .row_valid_o(row_valid_o), .row_last_o(row_last_o),
    .host_wr_req_i(host_wr_req_i), .host_wr_addr_i(host_wr_addr_i),
    .host_wr_data_i(host_wr_data_i), .host_wr_gnt_o(host_wr_gnt_o),
    .ram_cs_o(ram_cs_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  // RAM contents are a fixed function of the address so read data is predictable.
  function automatic logic [WW-1:0] pat(input logic [AW-1:0] a);
    return {16'h3000 | 16'(a), 16'h2000 | 16'(a), 16'h1000 | 16'(a), 16'(a)};
  endfunction

  logic [WW-1:0] rdata_q = '0;
  always @(posedge clk) begin
    if (ram_cs_o && !ram_we_o) rdata_q <= pat(ram_addr_o);
  end
  assign ram_rdata_i = rdata_q;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy_o && n < 60) begin
      step();
      n++;
    end
    ok = !busy_o;
  endtask

  task automatic test_reset;
    logic [7:0] ctl;
    rst_n = 1'b0;
    samp();
    ctl = {row_gnt_o, row_valid_o, row_last_o, host_wr_gnt_o, ram_cs_o, ram_we_o, busy_o, err_o};
    tests++;
    if (ctl !== 8'h00) begin fails++; $display("FAIL reset_ctl_in_reset: got %h exp 00", ctl); end
    step(); step();
    rst_n = 1'b1;
    samp();
    ctl = {row_gnt_o, row_valid_o, row_last_o, host_wr_gnt_o, ram_cs_o, ram_we_o, busy_o, err_o};
    tests++;
    if (ctl !== 8'h00) begin fails++; $display("FAIL reset_ctl_after: got %h exp 00", ctl); end
    tests++;
    if ({ram_addr_o, ram_wdata_o, row_data_o, row_mask_o} !== '0) begin
      fails++; $display("FAIL reset_buses: addr %h wdata %h data %h mask %h", ram_addr_o, ram_wdata_o, row_data_o, row_mask_o);
    end
  endtask

  task automatic test_row_fetch;
    logic          ecs [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [AW-1:0] ea  [5] = '{10'd48, 10'd49, 10'd50, 10'd0, 10'd0};
    logic          ev  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic          el  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [PW-1:0] em  [5] = '{4'h0, 4'hf, 4'hf, 4'h3, 4'h0};
    logic          eb  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [WW-1:0] ed  [5];
    logic [18:0]   obs, exp;
    bit ok;
    ed = '{64'h0, pat(10'd48), pat(10'd49), pat(10'd50), 64'h0};
    step();
    row_req_i = 1'b1; row_vidx_i = 6'd3; row_vnum_i = 7'd10;
    samp();
    tests++;
    if ({row_gnt_o, err_o, busy_o, ram_cs_o} !== 4'b1000) begin
      fails++; $display("FAIL row_grant: gnt/err/busy/cs got %b exp 1000", {row_gnt_o, err_o, busy_o, ram_cs_o});
    end
    step();
    row_req_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      samp();
      obs = {ram_cs_o, ram_we_o, ram_addr_o, row_valid_o, row_last_o, row_mask_o, busy_o};
      exp = {ecs[c], 1'b0, ea[c], ev[c], el[c], em[c], eb[c]};
      tests++;
      if (obs !== exp) begin fails++; $display("FAIL row_cycle_T+%0d: got %h exp %h", c + 1, obs, exp); end
      tests++;
      if (row_data_o !== ed[c]) begin fails++; $display("FAIL row_data_T+%0d: got %h exp %h", c + 1, row_data_o, ed[c]); end
      step();
    end
    wait_idle(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL row_fetch_idle: busy stuck, exp idle"); end
  endtask

  task automatic test_host_write;
    host_wr_req_i = 1'b1; host_wr_addr_i = 10'd5; host_wr_data_i = 64'hA5A5_A5A5_A5A5_A5A5;
    samp();
    tests++;
    if ({host_wr_gnt_o, ram_cs_o, ram_we_o, ram_addr_o} !== {3'b111, 10'd5}) begin
      fails++; $display("FAIL host_wr_ctl: gnt/cs/we %b addr %0d exp 111 addr 5", {host_wr_gnt_o, ram_cs_o, ram_we_o}, ram_addr_o);
    end
    tests++;
    if (ram_wdata_o !== 64'hA5A5_A5A5_A5A5_A5A5) begin fails++; $display("FAIL host_wr_data: got %h exp a5a5a5a5a5a5a5a5", ram_wdata_o); end
    tests++;
    if ({row_gnt_o, row_valid_o, row_last_o, busy_o, err_o} !== 5'b0) begin
      fails++; $display("FAIL host_wr_no_row: got %b exp 00000", {row_gnt_o, row_valid_o, row_last_o, busy_o, err_o});
    end
    step();
    host_wr_req_i = 1'b0;
    samp();
    tests++;
    if ({host_wr_gnt_o, ram_cs_o, ram_we_o, ram_addr_o, ram_wdata_o} !== '0) begin
      fails++; $display("FAIL host_wr_release: gnt/cs/we %b addr %h wdata %h exp all 0", {host_wr_gnt_o, ram_cs_o, ram_we_o}, ram_addr_o, ram_wdata_o);
    end
  endtask

  task automatic test_arbitration;
    bit ok;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    host_wr_req_i = 1'b1; host_wr_addr_i = 10'd7; host_wr_data_i = 64'h1234;
    row_req_i = 1'b1; row_vidx_i = 6'd0; row_vnum_i = 7'd4;
    samp();
    tests++;
    if ({host_wr_gnt_o, row_gnt_o} !== 2'b10) begin fails++; $display("FAIL arb_first_tie: host/row gnt got %b exp 10", {host_wr_gnt_o, row_gnt_o}); end
    step();
    host_wr_req_i = 1'b0;
    samp();
    tests++;
    if ({host_wr_gnt_o, row_gnt_o} !== 2'b01) begin fails++; $display("FAIL arb_row_next: host/row gnt got %b exp 01", {host_wr_gnt_o, row_gnt_o}); end
    step();
    host_wr_req_i = 1'b1; row_req_i = 1'b1; row_vidx_i = 6'd1;
    samp();
    tests++;
    if ({host_wr_gnt_o, row_gnt_o, ram_cs_o, ram_we_o} !== 4'b0010) begin
      fails++; $display("FAIL arb_wait_rowrd: gnts/cs/we got %b exp 0010", {host_wr_gnt_o, row_gnt_o, ram_cs_o, ram_we_o});
    end
    step();
    samp();
    tests++;
    if ({host_wr_gnt_o, row_gnt_o, row_valid_o, row_last_o} !== 4'b0011) begin
      fails++; $display("FAIL arb_wait_drain: gnts/valid/last got %b exp 0011", {host_wr_gnt_o, row_gnt_o, row_valid_o, row_last_o});
    end
    step();
    samp();
    tests++;
    if ({host_wr_gnt_o, row_gnt_o} !== 2'b10) begin fails++; $display("FAIL arb_second_tie: host/row gnt got %b exp 10", {host_wr_gnt_o, row_gnt_o}); end
    step();
    host_wr_req_i = 1'b0;
    samp();
    tests++;
    if (row_gnt_o !== 1'b1) begin fails++; $display("FAIL arb_row_after_host: row gnt got %b exp 1", row_gnt_o); end
    step();
    row_req_i = 1'b0;
    wait_idle(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL arb_idle: busy stuck, exp idle"); end
  endtask

  task automatic test_illegal;
    bit ok;
    row_req_i = 1'b1; row_vidx_i = 6'd0; row_vnum_i = 7'd0;
    samp();
    tests++;
    if ({err_o, row_gnt_o, ram_cs_o} !== 3'b100) begin fails++; $display("FAIL illegal_vnum0: err/gnt/cs got %b exp 100", {err_o, row_gnt_o, ram_cs_o}); end
    step();
    row_req_i = 1'b0;
    samp();
    tests++;
    if ({err_o, busy_o} !== 2'b00) begin fails++; $display("FAIL illegal_after: err/busy got %b exp 00", {err_o, busy_o}); end
    step();
    row_req_i = 1'b1; row_vidx_i = 6'd7; row_vnum_i = 7'd7;
    samp();
    tests++;
    if ({err_o, row_gnt_o, ram_cs_o} !== 3'b100) begin fails++; $display("FAIL illegal_vidx_eq_vnum: err/gnt/cs got %b exp 100", {err_o, row_gnt_o, ram_cs_o}); end
    step();
    row_vidx_i = 6'd0; row_vnum_i = 7'd65;
    samp();
    tests++;
    if ({err_o, row_gnt_o, ram_cs_o} !== 3'b100) begin fails++; $display("FAIL illegal_vnum65: err/gnt/cs got %b exp 100", {err_o, row_gnt_o, ram_cs_o}); end
    step();
    row_vidx_i = 6'd6; row_vnum_i = 7'd7;
    samp();
    tests++;
    if ({err_o, row_gnt_o} !== 2'b01) begin fails++; $display("FAIL legal_vidx6_vnum7: err/gnt got %b exp 01", {err_o, row_gnt_o}); end
    step();
    row_req_i = 1'b0;
    samp();
    tests++;
    if ({busy_o, ram_cs_o, ram_addr_o} !== {2'b11, 10'd96}) begin
      fails++; $display("FAIL legal_first_read: busy/cs %b addr %0d exp 11 addr 96", {busy_o, ram_cs_o}, ram_addr_o);
    end
    wait_idle(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL illegal_idle: busy stuck, exp idle"); end
  endtask

  task automatic test_host_during_row;
    int nvalid = 0, first_v = -1, last_c = -1, nlast = 0, data_err = 0, addr_err = 0, early_host = 0;
    logic host_ok = 1'b0;
    row_req_i = 1'b1; row_vidx_i = 6'd2; row_vnum_i = 7'd64;
    samp();
    tests++;
    if (row_gnt_o !== 1'b1) begin fails++; $display("FAIL full_row_grant: got %b exp 1", row_gnt_o); end
    step();
    row_req_i = 1'b0;
    host_wr_req_i = 1'b1; host_wr_addr_i = 10'd900; host_wr_data_i = 64'hDEAD_BEEF_0000_0001;
    for (int c = 1; c <= 18; c++) begin
      samp();
      if (c <= 16 && (ram_cs_o !== 1'b1 || ram_we_o !== 1'b0 || ram_addr_o !== AW'(32 + c - 1))) addr_err++;
      if (c < 18 && host_wr_gnt_o) early_host++;
      if (c == 18) host_ok = host_wr_gnt_o && ram_we_o && (ram_addr_o == 10'd900);
      if (row_valid_o) begin
        if (first_v < 0) first_v = c;
        last_c = c;
        nvalid++;
        if (row_data_o !== pat(AW'(32 + c - 2)) || row_mask_o !== 4'hf) data_err++;
      end
      if (row_last_o) nlast++;
      if (c == 17 && row_last_o !== 1'b1) nlast = 99;
      step();
      if (c == 18) host_wr_req_i = 1'b0;
    end
    tests++;
    if (addr_err !== 0) begin fails++; $display("FAIL full_row_addrs: %0d bad read cycles exp 0", addr_err); end
    tests++;
    if (early_host !== 0) begin fails++; $display("FAIL host_held_off: %0d early host grants exp 0", early_host); end
    tests++;
    if (host_ok !== 1'b1) begin fails++; $display("FAIL host_after_row: grant at T+18 got %b exp 1", host_ok); end
    tests++;
    if (nvalid !== 16 || first_v !== 2 || last_c !== 17) begin
      fails++; $display("FAIL full_row_valid: count %0d first %0d last %0d exp 16 2 17", nvalid, first_v, last_c);
    end
    tests++;
    if (nlast !== 1) begin fails++; $display("FAIL full_row_last: last count %0d exp 1 on word 16", nlast); end
    tests++;
    if (data_err !== 0) begin fails++; $display("FAIL full_row_data: %0d bad words exp 0", data_err); end
  endtask

  task automatic test_reset_mid_row;
    logic [AW-1:0] ea [4] = '{10'd16, 10'd17, 10'd18, 10'd0};
    logic          ev [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [PW-1:0] em [4] = '{4'h0, 4'hf, 4'hf, 4'h3};
    logic [17:0]   obs, exp;
    bit ok;
    row_req_i = 1'b1; row_vidx_i = 6'd1; row_vnum_i = 7'd10;
    samp();
    tests++;
    if (row_gnt_o !== 1'b1) begin fails++; $display("FAIL midrst_grant: got %b exp 1", row_gnt_o); end
    step();
    row_req_i = 1'b0;
    samp();
    tests++;
    if ({ram_cs_o, ram_addr_o} !== {1'b1, 10'd16}) begin fails++; $display("FAIL midrst_word0: cs %b addr %0d exp 1 16", ram_cs_o, ram_addr_o); end
    step();
    rst_n = 1'b0;
    samp();
    tests++;
    if ({row_gnt_o, row_valid_o, row_last_o, host_wr_gnt_o, ram_cs_o, ram_we_o, busy_o, err_o, ram_addr_o, row_mask_o, row_data_o} !== '0) begin
      fails++; $display("FAIL midrst_outputs: valid %b cs %b busy %b addr %h data %h exp all 0", row_valid_o, ram_cs_o, busy_o, ram_addr_o, row_data_o);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      samp();
      tests++;
      if ({row_valid_o, row_last_o, ram_cs_o, busy_o} !== 4'b0) begin
        fails++; $display("FAIL midrst_quiet_%0d: valid/last/cs/busy got %b exp 0000", c, {row_valid_o, row_last_o, ram_cs_o, busy_o});
      end
      step();
    end
    row_req_i = 1'b1;
    samp();
    tests++;
    if (row_gnt_o !== 1'b1) begin fails++; $display("FAIL midrst_regrant: got %b exp 1", row_gnt_o); end
    step();
    row_req_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      samp();
      obs = {(c < 3) ? ram_cs_o : ~ram_cs_o, ram_addr_o, row_valid_o, row_last_o, row_mask_o, busy_o};
      exp = {1'b1, ea[c], ev[c], (c == 3), em[c], 1'b1};
      tests++;
      if (obs !== exp) begin fails++; $display("FAIL midrst_refetch_%0d: got %h exp %h", c, obs, exp); end
      if (c > 0) begin
        tests++;
        if (row_data_o !== pat(AW'(16 + c - 1))) begin fails++; $display("FAIL midrst_data_%0d: got %h exp %h", c, row_data_o, pat(AW'(16 + c - 1))); end
      end
      step();
    end
    wait_idle(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL midrst_idle: busy stuck, exp idle"); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    row_req_i = 1'b1; row_vidx_i = 6'd0; row_vnum_i = 7'd4;
    for (int c = 0; c <= 6; c++) begin
      samp();
      tests++;
      if (row_gnt_o !== (c % 3 == 0)) begin fails++; $display("FAIL b2b_gnt_c%0d: got %b exp %b", c, row_gnt_o, (c % 3 == 0)); end
      step();
    end
    row_req_i = 1'b0;
    wait_idle(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_idle: busy stuck, exp idle"); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    row_req_i      = 1'b0;
    row_vidx_i     = '0;
    row_vnum_i     = '0;
    host_wr_req_i  = 1'b0;
    host_wr_addr_i = '0;
    host_wr_data_i = '0;
    test_reset();
    test_row_fetch();
    test_host_write();
    test_arbitration();
    test_illegal();
    test_host_during_row();
    test_reset_mid_row();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
